mul_product_combiner: RTL and testbench

- Downstream neighbour of the CPU multiplier cell.
- Consumes the three registered 16x16 partial products (lo*lo, lo*hi, hi*lo) produced in M stage and folds them into the 32-bit low word of the product.
- Two-stage valid/ready pipeline feeding the writeback/result mux, carrying the destination tag alongside.
- Supports backpressure and pipeline flush.

---
 rtl/mul_combiner_pkg.sv | 43 ++++
 rtl/mul_pipe_stage.sv | 56 +++++
 rtl/mul_product_combiner.sv | 137 +++++++++++++
 tb/tb_mul_product_combiner.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_combiner_pkg.sv
// rtl/mul_combiner_pkg.sv - shared widths, payload types and fold arithmetic for the product combiner
//
// Contents:
//   DATA_W       product word width (32)
//   HALF_W       half-word width (16)
//   TAG_W_DEF    default destination tag width (5)
//   s1_payload_t stage-1 payload at default tag width (p1, mid, tag)
//   result_t     result payload at default tag width (result, tag)
//   mid_sum      16-bit sum of the low halves of the cross partial products
//   fold_product low 32 bits of the product from p1 and the mid sum
package mul_combiner_pkg;

    localparam int DATA_W    = 32;
    localparam int HALF_W    = 16;
    localparam int TAG_W_DEF = 5;

    typedef struct packed {
        logic [DATA_W-1:0]    p1;
        logic [HALF_W-1:0]    mid;
        logic [TAG_W_DEF-1:0] tag;
    } s1_payload_t;

    typedef struct packed {
        logic [DATA_W-1:0]    result;
        logic [TAG_W_DEF-1:0] tag;
    } result_t;

    // Only the low halves of the cross products reach the low product word;
    // the carry out of bit 15 would land at bit 32 and is dropped.
    function automatic logic [HALF_W-1:0] mid_sum(input logic [HALF_W-1:0] a,
                                                  input logic [HALF_W-1:0] b);
        return a + b;
    endfunction

    // The low half of p1 passes straight through; only the upper half sees the mid sum.
    function automatic logic [DATA_W-1:0] fold_product(input logic [DATA_W-1:0] p1,
                                                       input logic [HALF_W-1:0] mid);
        logic [HALF_W-1:0] hi;
        hi = p1[DATA_W-1:HALF_W] + mid;
        return {hi, p1[HALF_W-1:0]};
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// rtl/mul_pipe_stage.sv - one valid/ready register slice with flush and async reset
//
// Parameters:
//   W          payload width
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   flush      synchronous kill of the held op and of any op offered this cycle
//   in_valid   upstream offers in_data
//   in_ready   slice can take an op this cycle (empty, or draining downstream)
//   in_data    payload from upstream
//   out_valid  slice holds an op
//   out_ready  downstream accepts the held op
//   out_data   held payload
module mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // An empty slice always accepts, so bubbles collapse.
    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
        end
    end

    // Data only moves on a real transfer so a stalled slice holds its payload stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (in_valid && in_ready && !flush) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/mul_product_combiner.sv
// rtl/mul_product_combiner.sv - folds three 16x16 partial products into the low product word
//
// Optional feature macro: MUL_COMBINER_PERF_CNT_EN (adds perf_ops / perf_stalls)
//
// Parameters:
//   TAG_W          destination tag width
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   M_mul_cell_p1  partial product src1[15:0]*src2[15:0]
//   M_mul_cell_p2  partial product src1[15:0]*src2[31:16]
//   M_mul_cell_p3  partial product src1[31:16]*src2[15:0]
//   M_valid        partial products and tag valid
//   M_tag          destination tag
//   M_ready        combiner accepts this cycle
//   flush          synchronous kill of all in-flight ops
//   A_mul_result   low 32 bits of the product
//   A_tag          tag of A_mul_result
//   A_valid        result valid
//   A_ready        consumer accepts result
//   busy           any stage holds a valid op
//   perf_ops       completed results (feature build only)
//   perf_stalls    cycles a valid result was refused (feature build only)
module mul_product_combiner
    import mul_combiner_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] M_mul_cell_p1,
    input  logic [DATA_W-1:0] M_mul_cell_p2,
    input  logic [DATA_W-1:0] M_mul_cell_p3,
    input  logic              M_valid,
    input  logic [TAG_W-1:0]  M_tag,
    output logic              M_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] A_mul_result,
    output logic [TAG_W-1:0]  A_tag,
    output logic              A_valid,
    input  logic              A_ready,
    output logic              busy
`ifdef MUL_COMBINER_PERF_CNT_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stalls
`endif
);

    // Same layout as the package payloads, sized by this instance's tag width.
    typedef struct packed {
        logic [DATA_W-1:0] p1;
        logic [HALF_W-1:0] mid;
        logic [TAG_W-1:0]  tag;
    } stage1_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tag;
    } stage2_t;

    localparam int S1_W = $bits(stage1_t);
    localparam int S2_W = $bits(stage2_t);

    stage1_t s1_in;
    stage1_t s1_out;
    stage2_t s2_in;
    stage2_t s2_out;
    logic    s1_valid;
    logic    s2_ready;

    // Upper halves of the cross products only affect bits 32 and above.
    logic    unused_hi_bits;
    assign unused_hi_bits = ^{M_mul_cell_p2[DATA_W-1:HALF_W], M_mul_cell_p3[DATA_W-1:HALF_W]};

    always_comb begin
        s1_in     = '0;
        s1_in.p1  = M_mul_cell_p1;
        s1_in.mid = mid_sum(M_mul_cell_p2[HALF_W-1:0], M_mul_cell_p3[HALF_W-1:0]);
        s1_in.tag = M_tag;
    end

    mul_pipe_stage #(
        .W (S1_W)
    ) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (M_valid),
        .in_ready  (M_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    always_comb begin
        s2_in        = '0;
        s2_in.result = fold_product(s1_out.p1, s1_out.mid);
        s2_in.tag    = s1_out.tag;
    end

    mul_pipe_stage #(
        .W (S2_W)
    ) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (A_valid),
        .out_ready (A_ready),
        .out_data  (s2_out)
    );

    assign A_mul_result = s2_out.result;
    assign A_tag        = s2_out.tag;
    assign busy         = s1_valid | A_valid;

`ifdef MUL_COMBINER_PERF_CNT_EN
    // Counters observe the output handshake only; flush does not touch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops    <= '0;
            perf_stalls <= '0;
        end else if (A_valid) begin
            if (A_ready) begin
                perf_ops <= perf_ops + 32'd1;
            end else begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_product_combiner.sv
// tb/tb_mul_product_combiner.sv - self-checking bench for mul_product_combiner
module tb_mul_product_combiner;

    logic        clk;
    logic        reset;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;
    logic        M_valid;
    logic [4:0]  M_tag;
    logic        M_ready;
    logic        flush;
    logic [31:0] A_mul_result;
    logic [4:0]  A_tag;
    logic        A_valid;
    logic        A_ready;
    logic        busy;
`ifdef MUL_COMBINER_PERF_CNT_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stalls;
`endif

    int total = 0;
    int bad   = 0;

    mul_product_combiner #(
        .TAG_W (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .M_mul_cell_p1 (M_mul_cell_p1),
        .M_mul_cell_p2 (M_mul_cell_p2),
        .M_mul_cell_p3 (M_mul_cell_p3),
        .M_valid       (M_valid),
        .M_tag         (M_tag),
        .M_ready       (M_ready),
        .flush         (flush),
        .A_mul_result  (A_mul_result),
        .A_tag         (A_tag),
        .A_valid       (A_valid),
        .A_ready       (A_ready),
        .busy          (busy)
`ifdef MUL_COMBINER_PERF_CNT_EN
        ,
        .perf_ops      (perf_ops),
        .perf_stalls   (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p1;
        logic [31:0] p2;
        logic [31:0] p3;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] model(input logic [31:0] p1, input logic [31:0] p2,
                                          input logic [31:0] p3);
        logic [31:0] s;
        s = p2 + p3;
        return p1 + (s << 16);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [31:0] p1, input logic [31:0] p2,
                            input logic [31:0] p3, input logic [4:0] tag);
        M_valid       = 1'b1;
        M_mul_cell_p1 = p1;
        M_mul_cell_p2 = p2;
        M_mul_cell_p3 = p3;
        M_tag         = tag;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Idle pipeline, A_ready=1: accept one op and check the two-cycle latency.
    task automatic single_op(input string name, input logic [31:0] p1, input logic [31:0] p2,
                             input logic [31:0] p3, input logic [4:0] tag,
                             input logic [31:0] exp);
        @(negedge clk);
        A_ready = 1'b1;
        drive_op(p1, p2, p3, tag);
        #1;
        chk({name, "_mready"}, {31'd0, M_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        M_valid = 1'b0;
        chk({name, "_valid_n1"}, {31'd0, A_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({name, "_valid_n2"}, {31'd0, A_valid}, 32'd1);
        chk({name, "_result"}, A_mul_result, exp);
        chk({name, "_tag"}, {27'd0, A_tag}, {27'd0, tag});
    endtask

    // Streams n_ops back-to-back ops, refusing the first n_stalls cycles of A_valid.
    task automatic run_stream(input string name, input int n_ops, input int n_stalls,
                              output bit mready_low);
        logic [31:0] exp_q[$];
        logic [4:0]  tag_q[$];
        logic [31:0] p1, p2, p3, held_res;
        logic [4:0]  held_tag;
        bit          held;
        int          sent, got, stall_left;
        sent       = 0;
        got        = 0;
        stall_left = n_stalls;
        held       = 1'b0;
        held_res   = '0;
        held_tag   = '0;
        mready_low = 1'b0;
        for (int cyc = 0; cyc < 60 && got < n_ops; cyc++) begin
            @(negedge clk);
            if (A_valid && stall_left > 0) begin
                A_ready = 1'b0;
                stall_left--;
            end else begin
                A_ready = 1'b1;
            end
            p1 = {16'(sent * 3 + 1), 16'(sent + 16)};
            p2 = 32'hF000_0000 | 32'(sent * 32'h111);
            p3 = 32'h0000_0100 * 32'(sent + 1);
            if (sent < n_ops) drive_op(p1, p2, p3, 5'(sent + 1));
            else M_valid = 1'b0;
            #1;
            if (!M_ready) mready_low = 1'b1;
            if (A_valid) begin
                if (held) begin
                    chk({name, "_stable_res"}, A_mul_result, held_res);
                    chk({name, "_stable_tag"}, {27'd0, A_tag}, {27'd0, held_tag});
                end
                if (A_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk({name, "_extra_output"}, 32'd1, 32'd0);
                    end else begin
                        chk({name, "_res"}, A_mul_result, exp_q.pop_front());
                        chk({name, "_tag"}, {27'd0, A_tag}, {27'd0, tag_q.pop_front()});
                    end
                    got++;
                end else begin
                    held     = 1'b1;
                    held_res = A_mul_result;
                    held_tag = A_tag;
                end
            end
            if (M_valid && M_ready) begin
                exp_q.push_back(model(p1, p2, p3));
                tag_q.push_back(5'(sent + 1));
                sent++;
            end
        end
        M_valid = 1'b0;
        A_ready = 1'b1;
        chk({name, "_count"}, 32'(got), 32'(n_ops));
    endtask

    initial begin
        bit mlow;

        vecs[0] = '{32'h0000_000F, 32'h0000_0006, 32'h0000_0005, 5'd7,  32'h000B_000F};
        vecs[1] = '{32'hFFFF_0001, 32'h0000_FFFF, 32'h0000_0001, 5'd3,  32'hFFFF_0001};
        vecs[2] = '{32'h0000_0005, 32'hABCD_0000, 32'h1234_0000, 5'd31, 32'h0000_0005};
        vecs[3] = '{32'h1234_5678, 32'h0000_0001, 32'h0000_0002, 5'd0,  32'h1237_5678};
        vecs[4] = '{32'h8000_FFFF, 32'hFFFF_8000, 32'h0000_8000, 5'd16, 32'h8000_FFFF};
        vecs[5] = '{32'h0000_0000, 32'h0000_7FFF, 32'h0000_7FFF, 5'd21, 32'hFFFE_0000};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5'd10, 32'h0000_FFFF};

        reset         = 1'b1;
        flush         = 1'b0;
        M_valid       = 1'b0;
        M_tag         = '0;
        M_mul_cell_p1 = '0;
        M_mul_cell_p2 = '0;
        M_mul_cell_p3 = '0;
        A_ready       = 1'b1;
        #12;
        chk("rst_mready", {31'd0, M_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_avalid", {31'd0, A_valid}, 32'd0);
        chk("rst_result", A_mul_result, 32'd0);
        chk("rst_tag", {27'd0, A_tag}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_mready", {31'd0, M_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            single_op($sformatf("vec%0d", i), vecs[i].p1, vecs[i].p2, vecs[i].p3,
                      vecs[i].tag, vecs[i].exp);
        end

        run_stream("bp", 4, 3, mlow);
        chk("bp_mready_dropped", {31'd0, mlow}, 32'd1);

        // Flush with both stages full and a third op offered while M_ready=1.
        @(negedge clk);
        A_ready = 1'b0;
        drive_op(32'h0000_0011, 32'h0000_0001, 32'h0000_0001, 5'd1);
        @(posedge clk);
        @(negedge clk);
        drive_op(32'h0000_0022, 32'h0000_0002, 32'h0000_0002, 5'd2);
        @(posedge clk);
        @(negedge clk);
        drive_op(32'h0000_0033, 32'h0000_0003, 32'h0000_0003, 5'd3);
        A_ready = 1'b1;
        flush   = 1'b1;
        #1;
        chk("fl_busy_before", {31'd0, busy}, 32'd1);
        chk("fl_mready", {31'd0, M_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush   = 1'b0;
        M_valid = 1'b0;
        chk("fl_avalid", {31'd0, A_valid}, 32'd0);
        chk("fl_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("fl_no_ghost", {31'd0, A_valid}, 32'd0);
        single_op("fl_fresh", 32'h0002_0004, 32'h0000_0010, 32'h0000_0020, 5'd9, 32'h0032_0004);

        // Async reset mid-cycle with both stages full.
        @(negedge clk);
        A_ready = 1'b0;
        drive_op(32'h1111_1111, 32'h0000_0001, 32'h0000_0001, 5'd4);
        @(posedge clk);
        @(negedge clk);
        drive_op(32'h2222_2222, 32'h0000_0002, 32'h0000_0002, 5'd5);
        @(posedge clk);
        @(negedge clk);
        M_valid = 1'b0;
        #1;
        chk("ar_busy_before", {31'd0, busy}, 32'd1);
        chk("ar_mready_before", {31'd0, M_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("ar_avalid", {31'd0, A_valid}, 32'd0);
        chk("ar_result", A_mul_result, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_mready", {31'd0, M_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ar_rel_mready", {31'd0, M_ready}, 32'd1);
        chk("ar_rel_busy", {31'd0, busy}, 32'd0);
        single_op("ar_post", 32'h0001_0003, 32'h0000_0002, 32'h0000_0001, 5'd12, 32'h0004_0003);

`ifdef MUL_COMBINER_PERF_CNT_EN
        do_reset();
        chk("perf_ops_rst", perf_ops, 32'd0);
        chk("perf_stalls_rst", perf_stalls, 32'd0);
        run_stream("perf", 5, 3, mlow);
        @(negedge clk);
        chk("perf_ops", perf_ops, 32'd5);
        chk("perf_stalls", perf_stalls, 32'd3);
        do_reset();
        chk("perf_ops_clr", perf_ops, 32'd0);
        chk("perf_stalls_clr", perf_stalls, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
